// File: rtl/aurora_rx_unpacker_pkg.sv
// Shared types and constants for the Aurora RX packet unpacker.
package aurora_rx_unpacker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SEND  = 2'd2
  } state_e;

  localparam int HDR_BITS = 8;

  // Number of stream beats carried by one FIFO word.
  function automatic int beats_per_pkt(input int packet_size, input int out_width);
    return packet_size / out_width;
  endfunction

endpackage

// File: rtl/aurora_rx_unpacker_if.sv
// Bus bundles for the unpacker: the RX FIFO read side and the AXI4-Stream
// master toward the PS/DMA. Master modport = the side that sources the data.
interface aurora_rx_fifo_if #(
  parameter int PACKET_SIZE = 128
) ();
  logic [PACKET_SIZE-1:0] rx_dout;
  logic                   rx_empty;
  logic                   rx_rd_en;

  // FIFO side
  modport master (output rx_dout, output rx_empty, input rx_rd_en);
  // reader side
  modport slave  (input rx_dout, input rx_empty, output rx_rd_en);
endinterface

interface aurora_axis_if import aurora_rx_unpacker_pkg::*; #(
  parameter int OUT_WIDTH = 32
) ();
  logic [OUT_WIDTH-1:0] m_axis_tdata;
  logic                 m_axis_tvalid;
  logic                 m_axis_tready;
  logic                 m_axis_tlast;
  logic [HDR_BITS-1:0]  m_axis_tuser;

  modport master (output m_axis_tdata, output m_axis_tvalid, input m_axis_tready,
                  output m_axis_tlast, output m_axis_tuser);
  modport slave  (input m_axis_tdata, input m_axis_tvalid, output m_axis_tready,
                  input m_axis_tlast, input m_axis_tuser);
endinterface

// File: rtl/aurora_rx_unpacker.sv
// Aurora RX unpacker: pops one PACKET_SIZE word from the RX FIFO (standard,
// non-FWFT read) and streams it MSB-word first as OUT_WIDTH AXI4-Stream beats.
// The header byte rides on tuser for the whole packet.
// Optional: define AURORA_RX_PKT_COUNT_EN to build the completed-packet counter;
// otherwise pkt_count is tied to zero.
module aurora_rx_unpacker
  import aurora_rx_unpacker_pkg::*;
#(
  parameter int PACKET_SIZE  = 128,
  parameter int OUT_WIDTH    = 32,
  parameter int COUNTER_BITS = 2
) (
  input  logic                  user_clk,
  input  logic                  RST,
  aurora_rx_fifo_if.slave       rx,
  aurora_axis_if.master         m_axis,
  output logic                  busy,
  output logic [31:0]           pkt_count
);

  localparam int BEATS = beats_per_pkt(PACKET_SIZE, OUT_WIDTH);
  localparam logic [COUNTER_BITS-1:0] LAST_BEAT = COUNTER_BITS'(BEATS - 1);

  state_e                  state, state_nxt;
  logic [PACKET_SIZE-1:0]  sreg;
  logic [COUNTER_BITS-1:0] beat_cnt;
  logic [HDR_BITS-1:0]     hdr;
  logic                    is_last;
  logic                    rd_en, tvalid, tlast;
  logic                    last_hs;

  assign is_last = (beat_cnt == LAST_BEAT);
  assign last_hs = (state == ST_SEND) && m_axis.m_axis_tready && is_last;

  // State register
  always_ff @(posedge user_clk or negedge RST) begin
    if (!RST) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // Next state and handshake outputs; reads are only issued from IDLE or on
  // the last-beat handshake, so a stalled beat never pulls a new word.
  always_comb begin
    state_nxt = state;
    rd_en     = 1'b0;
    tvalid    = 1'b0;
    tlast     = 1'b0;
    case (state)
      ST_IDLE: begin
        rd_en = !rx.rx_empty;
        if (!rx.rx_empty) state_nxt = ST_FETCH;
      end
      ST_FETCH: state_nxt = ST_SEND;
      ST_SEND: begin
        tvalid = 1'b1;
        tlast  = is_last;
        if (m_axis.m_axis_tready && is_last) begin
          if (!rx.rx_empty) begin
            rd_en     = 1'b1;
            state_nxt = ST_FETCH;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Shift register, header latch and beat index
  always_ff @(posedge user_clk or negedge RST) begin
    if (!RST) begin
      sreg     <= '0;
      hdr      <= '0;
      beat_cnt <= '0;
    end else if (state == ST_FETCH) begin
      sreg     <= rx.rx_dout;
      hdr      <= rx.rx_dout[PACKET_SIZE-1 -: HDR_BITS];
      beat_cnt <= '0;
    end else if (state == ST_SEND && m_axis.m_axis_tready && !is_last) begin
      sreg     <= {sreg[PACKET_SIZE-OUT_WIDTH-1:0], {OUT_WIDTH{1'b0}}};
      beat_cnt <= beat_cnt + 1'b1;
    end
  end

  assign rx.rx_rd_en          = rd_en;
  assign m_axis.m_axis_tvalid = tvalid;
  assign m_axis.m_axis_tlast  = tlast;
  assign m_axis.m_axis_tdata  = sreg[PACKET_SIZE-1 -: OUT_WIDTH];
  assign m_axis.m_axis_tuser  = hdr;
  assign busy                 = (state != ST_IDLE);

`ifdef AURORA_RX_PKT_COUNT_EN
  logic [31:0] pkt_cnt_q;

  // Completed-packet counter, wraps naturally at 2^32
  always_ff @(posedge user_clk or negedge RST) begin
    if (!RST)         pkt_cnt_q <= '0;
    else if (last_hs) pkt_cnt_q <= pkt_cnt_q + 32'd1;
  end

  assign pkt_count = pkt_cnt_q;
`else
  logic unused_last_hs;
  assign unused_last_hs = last_hs;
  assign pkt_count      = '0;
`endif

endmodule

// File: tb/tb_aurora_rx_unpacker.sv
// Directed bench for aurora_rx_unpacker with a small standard-read FIFO model.
module tb_aurora_rx_unpacker;

  localparam int PS = 128;
  localparam int OW = 32;

  logic        user_clk = 1'b0;
  logic        RST      = 1'b0;
  logic        busy;
  logic [31:0] pkt_count;

  always #5 user_clk = ~user_clk;

  aurora_rx_fifo_if #(.PACKET_SIZE(PS)) fif ();
  aurora_axis_if    #(.OUT_WIDTH(OW))   axs ();

  aurora_rx_unpacker #(.PACKET_SIZE(PS), .OUT_WIDTH(OW), .COUNTER_BITS(2)) dut (
    .user_clk  (user_clk),
    .RST       (RST),
    .rx        (fif),
    .m_axis    (axs),
    .busy      (busy),
    .pkt_count (pkt_count)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // FIFO model: standard read, data one cycle after rd_en
  logic [PS-1:0] mem [0:63];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int rd_bad = 0;

  assign fif.rx_empty = (wr_ptr == rd_ptr);

  always @(posedge user_clk) cyc <= cyc + 1;

  always @(posedge user_clk) begin
    if (fif.rx_rd_en) begin
      if (wr_ptr == rd_ptr) rd_bad <= rd_bad + 1;
      else begin
        fif.rx_dout <= mem[rd_ptr % 64];
        rd_ptr      <= rd_ptr + 1;
      end
    end
  end

  // Monitor: record accepted beats and read strobes mid-cycle
  logic [31:0] cap_d [0:127];
  logic        cap_l [0:127];
  logic [7:0]  cap_u [0:127];
  int          cap_c [0:127];
  int          cap_n = 0;
  int          rd_c  [0:127];
  int          rd_n  = 0;

  always @(negedge user_clk) begin
    if (axs.m_axis_tvalid && axs.m_axis_tready && cap_n < 128) begin
      cap_d[cap_n] <= axs.m_axis_tdata;
      cap_l[cap_n] <= axs.m_axis_tlast;
      cap_u[cap_n] <= axs.m_axis_tuser;
      cap_c[cap_n] <= cyc;
      cap_n        <= cap_n + 1;
    end
    if (fif.rx_rd_en && rd_n < 128) begin
      rd_c[rd_n] <= cyc;
      rd_n       <= rd_n + 1;
    end
  end

  // Packets and their hand-written beats
  localparam logic [PS-1:0] PA = 128'hA5112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [PS-1:0] P1 = 128'h11000001_11000002_11000003_11000004;
  localparam logic [PS-1:0] P2 = 128'h22000001_22000002_22000003_22000004;
  localparam logic [PS-1:0] P3 = 128'h33000001_33000002_33000003_33000004;
  localparam logic [PS-1:0] P4 = 128'h44AA0001_44AA0002_44AA0003_44AA0004;
  localparam logic [PS-1:0] P5 = 128'h55BB0001_55BB0002_55BB0003_55BB0004;

  logic [31:0] pa_b [0:3]  = '{32'hA5112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF};
  logic [31:0] bb_b [0:11] = '{32'h11000001, 32'h11000002, 32'h11000003, 32'h11000004,
                               32'h22000001, 32'h22000002, 32'h22000003, 32'h22000004,
                               32'h33000001, 32'h33000002, 32'h33000003, 32'h33000004};
  logic [7:0]  bb_u [0:2]  = '{8'h11, 8'h22, 8'h33};
  logic [31:0] p4_b [0:3]  = '{32'h44AA0001, 32'h44AA0002, 32'h44AA0003, 32'h44AA0004};
  logic [31:0] p5_b [0:3]  = '{32'h55BB0001, 32'h55BB0002, 32'h55BB0003, 32'h55BB0004};

  task automatic step();
    @(posedge user_clk);
    #1;
  endtask

  task automatic push(input logic [PS-1:0] w);
    mem[wr_ptr % 64] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic test_reset();
    axs.m_axis_tready = 1'b1;
    RST = 1'b0;
    repeat (3) step();
    checks++; if (fif.rx_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %b want 0", fif.rx_rd_en); end
    checks++; if (axs.m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %b want 0", axs.m_axis_tvalid); end
    checks++; if (axs.m_axis_tlast !== 1'b0) begin errors++; $display("FAIL reset_tlast: got %b want 0", axs.m_axis_tlast); end
    checks++; if (axs.m_axis_tdata !== 32'h0) begin errors++; $display("FAIL reset_tdata: got %h want 0", axs.m_axis_tdata); end
    checks++; if (axs.m_axis_tuser !== 8'h0) begin errors++; $display("FAIL reset_tuser: got %h want 0", axs.m_axis_tuser); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (pkt_count !== 32'h0) begin errors++; $display("FAIL reset_pkt_count: got %0d want 0", pkt_count); end
    RST = 1'b1;
    step();
  endtask

  task automatic test_single();
    int base, rbase, t0;
    axs.m_axis_tready = 1'b1;
    base = cap_n; rbase = rd_n;
    push(PA); t0 = cyc;
    repeat (10) step();
    checks++; if (cap_n - base !== 4) begin errors++; $display("FAIL single_beats: got %0d want 4", cap_n - base); end
    for (int j = 0; j < 4; j++) begin
      checks++; if (cap_d[base+j] !== pa_b[j]) begin errors++; $display("FAIL single_data[%0d]: got %h want %h", j, cap_d[base+j], pa_b[j]); end
      checks++; if (cap_l[base+j] !== (j == 3)) begin errors++; $display("FAIL single_tlast[%0d]: got %b want %b", j, cap_l[base+j], (j == 3)); end
    end
    checks++; if (cap_u[base] !== 8'hA5) begin errors++; $display("FAIL single_tuser: got %h want a5", cap_u[base]); end
    checks++; if (cap_c[base] !== t0 + 2) begin errors++; $display("FAIL single_latency: got cycle %0d want %0d", cap_c[base], t0 + 2); end
    checks++; if (rd_n - rbase !== 1) begin errors++; $display("FAIL single_rd_count: got %0d want 1", rd_n - rbase); end
    checks++; if (rd_c[rbase] !== t0) begin errors++; $display("FAIL single_rd_cycle: got %0d want %0d", rd_c[rbase], t0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    int base, rbase, t0, ec;
    axs.m_axis_tready = 1'b1;
    base = cap_n; rbase = rd_n;
    push(P1); push(P2); push(P3); t0 = cyc;
    repeat (20) step();
    checks++; if (cap_n - base !== 12) begin errors++; $display("FAIL b2b_beats: got %0d want 12", cap_n - base); end
    for (int j = 0; j < 12; j++) begin
      ec = t0 + 2 + 5 * (j / 4) + (j % 4);
      checks++; if (cap_d[base+j] !== bb_b[j]) begin errors++; $display("FAIL b2b_data[%0d]: got %h want %h", j, cap_d[base+j], bb_b[j]); end
      checks++; if (cap_c[base+j] !== ec) begin errors++; $display("FAIL b2b_cycle[%0d]: got %0d want %0d", j, cap_c[base+j], ec); end
      checks++; if (cap_l[base+j] !== (j % 4 == 3)) begin errors++; $display("FAIL b2b_tlast[%0d]: got %b want %b", j, cap_l[base+j], (j % 4 == 3)); end
      checks++; if (cap_u[base+j] !== bb_u[j/4]) begin errors++; $display("FAIL b2b_tuser[%0d]: got %h want %h", j, cap_u[base+j], bb_u[j/4]); end
    end
    checks++; if (rd_n - rbase !== 3) begin errors++; $display("FAIL b2b_rd_count: got %0d want 3", rd_n - rbase); end
    for (int j = 0; j < 3; j++) begin
      checks++; if (rd_c[rbase+j] !== t0 + 5 * j) begin errors++; $display("FAIL b2b_rd_cycle[%0d]: got %0d want %0d", j, rd_c[rbase+j], t0 + 5 * j); end
    end
  endtask

  task automatic test_stall();
    int base, rbase, t0;
    axs.m_axis_tready = 1'b1;
    base = cap_n; rbase = rd_n;
    push(PA); t0 = cyc;
    repeat (3) step();
    axs.m_axis_tready = 1'b0;
    push(P4);
    for (int k = 0; k < 5; k++) begin
      checks++; if (axs.m_axis_tdata !== 32'h44556677) begin errors++; $display("FAIL stall_tdata[%0d]: got %h want 44556677", k, axs.m_axis_tdata); end
      checks++; if (axs.m_axis_tlast !== 1'b0) begin errors++; $display("FAIL stall_tlast[%0d]: got %b want 0", k, axs.m_axis_tlast); end
      checks++; if (axs.m_axis_tvalid !== 1'b1) begin errors++; $display("FAIL stall_tvalid[%0d]: got %b want 1", k, axs.m_axis_tvalid); end
      checks++; if (fif.rx_rd_en !== 1'b0) begin errors++; $display("FAIL stall_rd_en[%0d]: got %b want 0", k, fif.rx_rd_en); end
      checks++; if (axs.m_axis_tuser !== 8'hA5) begin errors++; $display("FAIL stall_tuser[%0d]: got %h want a5", k, axs.m_axis_tuser); end
      step();
    end
    axs.m_axis_tready = 1'b1;
    repeat (12) step();
    checks++; if (cap_n - base !== 8) begin errors++; $display("FAIL stall_beats: got %0d want 8", cap_n - base); end
    for (int j = 0; j < 4; j++) begin
      checks++; if (cap_d[base+j] !== pa_b[j]) begin errors++; $display("FAIL stall_data[%0d]: got %h want %h", j, cap_d[base+j], pa_b[j]); end
      checks++; if (cap_d[base+4+j] !== p4_b[j]) begin errors++; $display("FAIL stall_next_data[%0d]: got %h want %h", j, cap_d[base+4+j], p4_b[j]); end
    end
    checks++; if (cap_c[base+1] !== t0 + 8) begin errors++; $display("FAIL stall_release_cycle: got %0d want %0d", cap_c[base+1], t0 + 8); end
    checks++; if (rd_n - rbase !== 2) begin errors++; $display("FAIL stall_rd_count: got %0d want 2", rd_n - rbase); end
    checks++; if (rd_c[rbase+1] !== t0 + 10) begin errors++; $display("FAIL stall_rd_cycle: got %0d want %0d", rd_c[rbase+1], t0 + 10); end
  endtask

  task automatic test_reset_mid();
    int base, t1;
    axs.m_axis_tready = 1'b1;
    push(PA);
    repeat (4) step();
    checks++; if (axs.m_axis_tdata !== 32'h8899AABB) begin errors++; $display("FAIL rstmid_pre_tdata: got %h want 8899aabb", axs.m_axis_tdata); end
    #2 RST = 1'b0;
    #1;
    checks++; if (axs.m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL rstmid_tvalid: got %b want 0", axs.m_axis_tvalid); end
    checks++; if (axs.m_axis_tlast !== 1'b0) begin errors++; $display("FAIL rstmid_tlast: got %b want 0", axs.m_axis_tlast); end
    checks++; if (axs.m_axis_tdata !== 32'h0) begin errors++; $display("FAIL rstmid_tdata: got %h want 0", axs.m_axis_tdata); end
    checks++; if (axs.m_axis_tuser !== 8'h0) begin errors++; $display("FAIL rstmid_tuser: got %h want 0", axs.m_axis_tuser); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    checks++; if (fif.rx_rd_en !== 1'b0) begin errors++; $display("FAIL rstmid_rd_en: got %b want 0", fif.rx_rd_en); end
    step(); step();
    RST = 1'b1;
    base = cap_n;
    push(P5); t1 = cyc;
    repeat (8) step();
    checks++; if (cap_n - base !== 4) begin errors++; $display("FAIL rstmid_beats: got %0d want 4", cap_n - base); end
    checks++; if (cap_c[base] !== t1 + 2) begin errors++; $display("FAIL rstmid_latency: got %0d want %0d", cap_c[base], t1 + 2); end
    checks++; if (cap_u[base] !== 8'h55) begin errors++; $display("FAIL rstmid_tuser_new: got %h want 55", cap_u[base]); end
    for (int j = 0; j < 4; j++) begin
      checks++; if (cap_d[base+j] !== p5_b[j]) begin errors++; $display("FAIL rstmid_data[%0d]: got %h want %h", j, cap_d[base+j], p5_b[j]); end
    end
  endtask

  task automatic test_idle();
    int bad = 0;
    for (int k = 0; k < 100; k++) begin
      if (fif.rx_rd_en !== 1'b0 || axs.m_axis_tvalid !== 1'b0 || busy !== 1'b0) bad++;
      step();
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL idle_quiet: got %0d active cycles want 0", bad); end
    checks++; if (rd_bad !== 0) begin errors++; $display("FAIL read_while_empty: got %0d want 0", rd_bad); end
  endtask

  task automatic test_pkt_count();
    int base, exp_cnt;
`ifdef AURORA_RX_PKT_COUNT_EN
    exp_cnt = 5;
`else
    exp_cnt = 0;
`endif
    RST = 1'b0;
    step();
    RST = 1'b1;
    step();
    checks++; if (pkt_count !== 32'h0) begin errors++; $display("FAIL count_after_reset: got %0d want 0", pkt_count); end
    base = cap_n;
    axs.m_axis_tready = 1'b1;
    push(P1); push(P2); push(P3); push(P4); push(P5);
    repeat (40) step();
    checks++; if (cap_n - base !== 20) begin errors++; $display("FAIL count_beats: got %0d want 20", cap_n - base); end
    checks++; if (cap_d[base+19] !== 32'h55BB0004) begin errors++; $display("FAIL count_final_beat: got %h want 55bb0004", cap_d[base+19]); end
    checks++; if (pkt_count !== 32'(exp_cnt)) begin errors++; $display("FAIL pkt_count: got %0d want %0d", pkt_count, exp_cnt); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    axs.m_axis_tready = 1'b1;
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    test_idle();
    test_pkt_count();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/aurora_rx_unpacker.md
# aurora_rx_unpacker

Drains the Aurora RX packet FIFO, which the receiver fills with `PACKET_SIZE`-bit words, and serialises each packet into `OUT_WIDTH`-bit AXI4-Stream beats toward the Zynq PS/DMA side. It sits directly downstream of the RX FIFO in the `user_clk` domain. The packet header byte, bits [PACKET_SIZE-1 -: 8], is exposed as `m_axis_tuser` for the whole packet.

## Interface
Parameters:
- `PACKET_SIZE`, 128: FIFO word width in bits; must be a multiple of `OUT_WIDTH`.
- `OUT_WIDTH`, 32: stream beat width.
- `COUNTER_BITS`, 2: beat-index width, equal to log2(PACKET_SIZE/OUT_WIDTH).

Ports:
- `user_clk` in 1: the block's single clock.
- `RST` in 1: reset, asynchronous and active-low.
- `rx_dout` in PACKET_SIZE: RX FIFO read data. It is valid the cycle after `rx_rd_en` (standard FIFO, not first-word-fall-through).
- `rx_empty` in 1: RX FIFO empty flag.
- `rx_rd_en` out 1: RX FIFO read strobe.
- `m_axis_tdata` out OUT_WIDTH: stream data.
- `m_axis_tvalid` out 1: stream valid.
- `m_axis_tready` in 1: stream ready.
- `m_axis_tlast` out 1: marks the final beat of a packet.
- `m_axis_tuser` out 8: packet header byte.
- `busy` out 1: high in any state other than IDLE.
- `pkt_count` out 32: count of completed packets (see Configuration).

## Operation
- FSM states are IDLE, FETCH and SEND.
- IDLE:
  - `rx_rd_en` = !rx_empty, combinational in this state only.
  - If `rx_empty` = 0, go to FETCH.
- FETCH (exactly one cycle):
  - Latch `rx_dout` into the shift register.
  - Latch `rx_dout[PACKET_SIZE-1 -: 8]` into `m_axis_tuser`.
  - Clear `beat_cnt` to 0 and go to SEND.
- SEND:
  - `m_axis_tvalid` = 1.
  - `m_axis_tdata` = shift register MSB word. The first beat is bits [PACKET_SIZE-1 -: OUT_WIDTH].
  - `m_axis_tlast` = (beat_cnt == PACKET_SIZE/OUT_WIDTH-1).
  - On a handshake (tvalid && tready) that is not the last beat: shift left by `OUT_WIDTH` and increment `beat_cnt`.
  - On the last-beat handshake with `rx_empty` = 0: assert `rx_rd_en` in that same cycle and go to FETCH (back-to-back packets).
  - On the last-beat handshake with `rx_empty` = 1: go to IDLE.
- `rx_rd_en` is never asserted while `rx_empty` = 1. At most one FIFO read is outstanding per packet.
- While tvalid && !tready, `tdata`, `tlast` and `tuser` hold stable and no new FIFO read is issued.
- `beat_cnt` is `COUNTER_BITS` wide. It never wraps inside a packet, because it is cleared in FETCH.

## Timing
- Reset values: `rx_rd_en` 0, `m_axis_tvalid` 0, `m_axis_tlast` 0, `m_axis_tdata` 0, `m_axis_tuser` 0, `busy` 0, `pkt_count` 0. FSM resets to IDLE.
- Latency: with `rx_empty` falling in cycle N (IDLE), `rx_rd_en` is high in cycle N, FETCH is cycle N+1, and the first `m_axis_tvalid` is in cycle N+2.
- Throughput with `tready` held at 1:
  - isolated packet: PACKET_SIZE/OUT_WIDTH + 2 cycles;
  - back-to-back packets: PACKET_SIZE/OUT_WIDTH + 1 cycles per packet.
- `RST` asserted mid-packet: the held packet is discarded and that FIFO entry is lost. Outputs return to reset values asynchronously. Deassertion is synchronised externally.
- `rx_empty` toggling during SEND has no effect until the last-beat handshake.

## Configuration
- `AURORA_RX_PKT_COUNT_EN` defined:
  - `pkt_count` increments on every last-beat handshake and wraps from 0xFFFFFFFF to 0.
- Not defined:
  - `pkt_count` is tied to 0 and no counter logic is synthesised.
  - The port remains, so the upper level is unchanged.

## Structure
- Shared package holds:
  - the FSM state enum (IDLE/FETCH/SEND);
  - `HDR_BITS` = 8;
  - `beats_per_pkt(PACKET_SIZE, OUT_WIDTH)` as a constant function.
- No sub-module. The shift register, beat counter and FSM are one module.

## Test plan
- Single packet 0xA5_112233_44556677_8899AABB_CCDDEEFF, `tready` always 1:
  - beats 0xA5112233, 0x44556677, 0x8899AABB, 0xCCDDEEFF, with `tlast` on beat 4;
  - `tuser` = 0xA5;
  - first `tvalid` 2 cycles after `rx_empty` falls; `rx_rd_en` pulses exactly once.
- Three queued packets, `tready` = 1:
  - 12 beats in 15 cycles, with no gap between a `tlast` beat and the next FETCH;
  - `rx_rd_en` high in IDLE and in the two last-beat cycles.
- `tready` low for 5 cycles on beat 2:
  - `tdata` stays at 0x44556677 with `tlast` = 0;
  - `rx_rd_en` stays 0 throughout.
- `RST` asserted on beat 3:
  - all outputs go to 0 immediately;
  - after release with a new packet queued, the next packet streams from beat 1.
- `rx_empty` held 1 for 100 cycles: `rx_rd_en`, `tvalid` and `busy` all stay 0.
- With `AURORA_RX_PKT_COUNT_EN` defined, 5 packets sent: `pkt_count` = 5. Without the macro: `pkt_count` = 0.
